tree_adder_arbiter: RTL and testbench

Round-robin arbiter that time-shares one combinational TreeAdder instance among NUM_REQ requesters in the Conv2D 3x3 datapath. Each requester presents one 3x3 window of products (NUM_TERMS words). The block grants one requester per cycle, reduces its terms through the shared adder, and returns the registered sum tagged with the requester ID over a valid/ready handshake.

---
 rtl/conv2d_pkg.sv | 28 ++
 rtl/rr_grant.sv | 34 +++
 rtl/tree_adder.sv | 27 ++
 rtl/tree_adder_arbiter.sv | 128 ++++++++++++
 tb/tb_tree_adder_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_pkg.sv
// Shared Conv2D datapath constants and width helpers.
package conv2d_pkg;

   localparam int DEF_WORD_WIDTH = 8;
   localparam int DEF_NUM_TERMS  = 9;

   function automatic int clog2(input int n);
      int r;
      int one;
      r   = 0;
      one = 1;
      for (int i = 0; i < 31; i++) begin
         if ((one << i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic int id_w(input int n);
      int c;
      c = clog2(n);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Pointer-based round-robin select: first eligible index at or after i_ptr.
module rr_grant
   import conv2d_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_elig,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_grant_id
);

   int   w_idx;
   logic w_found;

   always_comb begin
      o_grant    = '0;
      o_grant_id = '0;
      w_found    = 1'b0;
      w_idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(i_ptr) + k) % NUM_REQ;
         if (!w_found && i_elig[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_grant_id     = ID_W'(w_idx);
            w_found        = 1'b1;
         end else begin
            w_found = w_found;
         end
      end
   end

endmodule

// File: rtl/tree_adder.sv
// Combinational pairwise reduction of NUM_TERMS words, modulo 2^WORD_WIDTH.
module TreeAdder
   import conv2d_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int NUM_TERMS  = DEF_NUM_TERMS
) (
   input  logic [NUM_TERMS*WORD_WIDTH-1:0] i_terms,
   output logic [WORD_WIDTH-1:0]           o_sum
);

   logic [WORD_WIDTH-1:0] w_lvl [NUM_TERMS];

   // In-place tree: an unpaired odd term simply rides up to the next level.
   always_comb begin
      for (int i = 0; i < NUM_TERMS; i++) begin
         w_lvl[i] = i_terms[i*WORD_WIDTH +: WORD_WIDTH];
      end
      for (int step = 1; step < NUM_TERMS; step = step * 2) begin
         for (int i = 0; i + step < NUM_TERMS; i = i + 2 * step) begin
            w_lvl[i] = w_lvl[i] + w_lvl[i + step];
         end
      end
      o_sum = w_lvl[0];
   end

endmodule

// File: rtl/tree_adder_arbiter.sv
// Round-robin sharing of one TreeAdder among NUM_REQ requesters with a registered result slot.
// Optional per-requester accumulation is compiled in with ADDER_ARB_ACCUM_EN.
module tree_adder_arbiter
   import conv2d_pkg::*;
#(
   parameter  int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter  int NUM_TERMS  = DEF_NUM_TERMS,
   parameter  int NUM_REQ    = 4,
   localparam int ID_W       = id_w(NUM_REQ)
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic [NUM_REQ-1:0]                     i_req_valid,
   output logic [NUM_REQ-1:0]                     o_req_ready,
   input  logic [NUM_REQ*NUM_TERMS*WORD_WIDTH-1:0] i_req_terms,
   input  logic [NUM_REQ-1:0]                     i_req_last,
   output logic                                   o_res_valid,
   input  logic                                   i_res_ready,
   output logic [WORD_WIDTH-1:0]                  o_res_sum,
   output logic [ID_W-1:0]                        o_res_id
);

   localparam int TERM_BITS = NUM_TERMS * WORD_WIDTH;

   logic [ID_W-1:0]       r_rr_ptr;
   logic                  r_res_valid;
   logic [WORD_WIDTH-1:0] r_res_sum;
   logic [ID_W-1:0]       r_res_id;

   logic                  w_slot_free;
   logic [NUM_REQ-1:0]    w_elig;
   logic [NUM_REQ-1:0]    w_grant;
   logic [ID_W-1:0]       w_grant_id;
   logic                  w_accept;
   logic [TERM_BITS-1:0]  w_terms;
   logic [WORD_WIDTH-1:0] w_sum;
   logic [WORD_WIDTH-1:0] w_total;
   logic                  w_produce;

   assign w_slot_free = ~r_res_valid | i_res_ready;
   assign w_accept    = |w_grant;
   assign o_req_ready = w_grant;
   assign o_res_valid = r_res_valid;
   assign o_res_sum   = r_res_sum;
   assign o_res_id    = r_res_id;

   // Non-final beats fold into an accumulator and never need the result slot.
   always_comb begin
      w_elig = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
`ifdef ADDER_ARB_ACCUM_EN
         w_elig[r] = i_req_valid[r] & (w_slot_free | ~i_req_last[r]);
`else
         w_elig[r] = i_req_valid[r] & w_slot_free;
`endif
      end
   end

   rr_grant #(
      .NUM_REQ    (NUM_REQ),
      .ID_W       (ID_W)
   ) u_rr_grant (
      .i_elig     (w_elig),
      .i_ptr      (r_rr_ptr),
      .o_grant    (w_grant),
      .o_grant_id (w_grant_id)
   );

   assign w_terms = i_req_terms[w_grant_id*TERM_BITS +: TERM_BITS];

   TreeAdder #(
      .WORD_WIDTH (WORD_WIDTH),
      .NUM_TERMS  (NUM_TERMS)
   ) u_tree_adder (
      .i_terms    (w_terms),
      .o_sum      (w_sum)
   );

`ifdef ADDER_ARB_ACCUM_EN
   logic [WORD_WIDTH-1:0] r_acc [NUM_REQ];

   assign w_total   = r_acc[w_grant_id] + w_sum;
   assign w_produce = w_accept & i_req_last[w_grant_id];

   // Per-requester partial sums; cleared when the group's last beat is taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            r_acc[r] <= '0;
         end
      end else if (w_accept) begin
         if (i_req_last[w_grant_id]) begin
            r_acc[w_grant_id] <= '0;
         end else begin
            r_acc[w_grant_id] <= w_total;
         end
      end
   end
`else
   logic w_unused_last;

   assign w_unused_last = ^i_req_last;
   assign w_total       = w_sum;
   assign w_produce     = w_accept;
`endif

   // Result slot and round-robin pointer; a drain and a refill in one cycle keeps the slot full.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_ptr    <= '0;
         r_res_valid <= 1'b0;
         r_res_sum   <= '0;
         r_res_id    <= '0;
      end else begin
         if (w_produce) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_total;
            r_res_id    <= w_grant_id;
         end else if (r_res_valid && i_res_ready) begin
            r_res_valid <= 1'b0;
         end
         if (w_accept) begin
            r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tree_adder_arbiter.sv
// Directed bench for tree_adder_arbiter; covers both ADDER_ARB_ACCUM_EN builds.
module tb_tree_adder_arbiter;

   localparam int W  = 8;
   localparam int T  = 9;
   localparam int N  = 4;
   localparam int IW = 2;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*T*W-1:0] req_terms;
   logic [N-1:0]     req_last;
   logic             res_valid;
   logic             res_ready;
   logic [W-1:0]     res_sum;
   logic [IW-1:0]    res_id;

   int checks;
   int failures;

   tree_adder_arbiter #(
      .WORD_WIDTH (W),
      .NUM_TERMS  (T),
      .NUM_REQ    (N)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_terms (req_terms),
      .i_req_last  (req_last),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_sum   (res_sum),
      .o_res_id    (res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_terms(input int r, input int base, input int inc);
      for (int j = 0; j < T; j++) begin
         req_terms[r*T*W + j*W +: W] = W'(base + inc * j);
      end
   endtask

   task automatic chk_res(input string tag, input logic v, input int s, input int id);
      chk({tag, "_valid"}, {31'd0, res_valid}, {31'd0, v});
      chk({tag, "_sum"}, {24'd0, res_sum}, 32'(s));
      chk({tag, "_id"}, {30'd0, res_id}, 32'(id));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_terms = '0;
      req_last  = '0;
      res_ready = 1'b1;

      #2;
      chk_res("reset", 1'b0, 0, 0);
      chk("reset_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // Round robin: all valid, all terms 1 -> grants 0,1,2,3,0,... sum 9 each
      for (int r = 0; r < N; r++) set_terms(r, 1, 0);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rr_ready", {28'd0, req_ready}, 32'd1 << (k % 4));
         if (k > 0) chk_res("rr_res", 1'b1, 9, (k - 1) % 4);
         next_cycle();
      end
      req_valid = '0;
      @(negedge clk);
      chk_res("rr_tail", 1'b1, 9, 3);
      chk("rr_tail_ready", {28'd0, req_ready}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("rr_drained", {31'd0, res_valid}, 32'd0);

      // Single request from r2, terms 1..9
      set_terms(2, 1, 1);
      req_valid = 4'b0100;
      #1;
      chk("single_ready", {28'd0, req_ready}, 32'd4);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk_res("single", 1'b1, 45, 2);

      // Overflow: nine terms of 255 -> 2295 mod 256 = 247 (ptr now 3, r0 only valid)
      next_cycle();
      set_terms(0, 255, 0);
      req_valid = 4'b0001;
      #1;
      chk("ovf_ready", {28'd0, req_ready}, 32'd1);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk_res("ovf", 1'b1, 247, 0);
      next_cycle();

      // Backpressure: ptr=1, r0 sums 18, r1 sums 27; first grant r1, then hold
      set_terms(0, 2, 0);
      set_terms(1, 3, 0);
      res_ready = 1'b0;
      req_valid = 4'b0011;
      #1;
      chk("bp_first_ready", {28'd0, req_ready}, 32'd2);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_hold_ready", {28'd0, req_ready}, 32'd0);
         chk_res("bp_hold", 1'b1, 27, 1);
         next_cycle();
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_ready", {28'd0, req_ready}, 32'd1);
      chk_res("bp_release_old", 1'b1, 27, 1);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk_res("bp_refill", 1'b1, 18, 0);
      next_cycle();

      // Accumulation: r1 three beats of ones, last on the third (ptr=1)
      set_terms(1, 1, 0);
      req_valid = 4'b0010;
      for (int b = 0; b < 3; b++) begin
         req_last = (b == 2) ? 4'b0010 : 4'b0000;
         #1;
         chk("acc_ready", {28'd0, req_ready}, 32'd2);
         if (b > 0) begin
`ifdef ADDER_ARB_ACCUM_EN
            chk("acc_no_result", {31'd0, res_valid}, 32'd0);
`else
            chk_res("acc_beat", 1'b1, 9, 1);
`endif
         end
         next_cycle();
      end
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
`ifdef ADDER_ARB_ACCUM_EN
      chk_res("acc_final", 1'b1, 27, 1);
`else
      chk_res("acc_final", 1'b1, 9, 1);
`endif
      next_cycle();
      // A fresh single last beat shows acc[1] was cleared (ptr=2, only r1 valid)
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      #1;
      chk("acc_clr_ready", {28'd0, req_ready}, 32'd2);
      next_cycle();
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      chk_res("acc_cleared", 1'b1, 9, 1);
      next_cycle();

      // Reset while FULL and with r3 mid-accumulation (ptr=2)
      set_terms(3, 1, 0);
      set_terms(0, 1, 0);
      req_valid = 4'b1000;
      req_last  = 4'b0000;
      next_cycle();
      req_valid = 4'b0001;
      req_last  = 4'b0001;
      #1;
      chk("pre_rst_ready", {28'd0, req_ready}, 32'd1);
      next_cycle();
      req_valid = '0;
      req_last  = '0;
      res_ready = 1'b0;
      @(negedge clk);
      chk_res("pre_rst", 1'b1, 9, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_res("mid_rst", 1'b0, 0, 0);
      chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      req_valid = 4'b1010;
      req_last  = 4'b1010;
      #1;
      chk("post_rst_ready", {28'd0, req_ready}, 32'd2);
      next_cycle();
      @(negedge clk);
      chk_res("post_rst_r1", 1'b1, 9, 1);
      chk("post_rst_ready2", {28'd0, req_ready}, 32'd8);
      next_cycle();
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      chk_res("post_rst_r3", 1'b1, 9, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
